// File: rtl/stream_sender_pkg.sv
// ============================================================================
// stream_sender_pkg: shared widths and FSM state encoding for stream_sender.
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_sender_pkg;

  localparam int SS_DWIDTH = 32;
  localparam int SS_LWIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_sender_if.sv
// ============================================================================
// stream_sender_if: FIFO read port plus AXI4-Stream master bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface stream_sender_if #(
  parameter int DWIDTH = 32
);

  logic              buf_isempty;
  logic [DWIDTH-1:0] buf_rdata;
  logic              buf_re;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tlast;

  modport master (
    input  buf_isempty,
    input  buf_rdata,
    output buf_re,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tlast
  );

  modport slave (
    output buf_isempty,
    output buf_rdata,
    input  buf_re,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tlast
  );

endinterface

`default_nettype wire

// File: rtl/stream_sender_axis_reg_slice.sv
// ============================================================================
// axis_reg_slice: one-entry valid/data/last output register for stream_sender.
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_reg_slice #(
  parameter int DWIDTH = 32
) (
  input  wire              clk,
  input  wire              xrst,
  input  wire              i_load,
  input  wire [DWIDTH-1:0] i_data,
  input  wire              i_last,
  input  wire              i_unload,
  output logic             o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic             o_last
);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic              r_last;

  // A load in the same cycle as an unload reloads the entry, so no bubble.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_valid && r_last;

endmodule

`default_nettype wire

// File: rtl/stream_sender.sv
// ============================================================================
// stream_sender: drains the buffer FIFO as one AXI4-Stream packet per start.
// Optional stall counter: define STREAM_SENDER_STALL_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module stream_sender
  import stream_sender_pkg::*;
#(
  parameter int DWIDTH = SS_DWIDTH,
  parameter int LWIDTH = SS_LWIDTH
) (
  input  wire              clk,
  input  wire              xrst,
  input  wire              start,
  input  wire [LWIDTH-1:0] pkt_len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      stall_cycles,
  stream_sender_if.master  bus
);

  localparam logic [LWIDTH-1:0] c_one = LWIDTH'(1);

  state_t            r_state;
  logic [LWIDTH-1:0] r_len;
  logic [LWIDTH-1:0] r_popped;
  logic [LWIDTH-1:0] r_sent;
  logic              r_busy;
  logic              r_done;

  logic              w_valid;
  logic              w_pop;
  logic              w_hs;
  logic              w_last_pop;
  logic              w_start_acc;

  assign w_start_acc = (r_state == S_IDLE) && start && (pkt_len != '0);
  assign w_hs        = w_valid && bus.m_axis_tready;
  assign w_pop       = (r_state == S_RUN) && !bus.buf_isempty &&
                       (r_popped != r_len) && (!w_valid || bus.m_axis_tready);
  assign w_last_pop  = (r_popped == r_len - c_one);

  axis_reg_slice #(
    .DWIDTH (DWIDTH)
  ) u_slice (
    .clk      (clk),
    .xrst     (xrst),
    .i_load   (w_pop),
    .i_data   (bus.buf_rdata),
    .i_last   (w_last_pop),
    .i_unload (w_hs),
    .o_valid  (w_valid),
    .o_data   (bus.m_axis_tdata),
    .o_last   (bus.m_axis_tlast)
  );

  // Leaves S_RUN on the edge of the final handshake so done follows it directly.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_popped <= '0;
      r_sent   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_len    <= pkt_len;
            r_popped <= '0;
            r_sent   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            r_popped <= r_popped + c_one;
          end
          if (w_hs) begin
            r_sent <= r_sent + c_one;
            if (r_sent + c_one == r_len) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign bus.buf_re        = w_pop;
  assign bus.m_axis_tvalid = w_valid;

`ifdef STREAM_SENDER_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if (w_valid && !bus.m_axis_tready && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/stream_sender.md
# stream_sender

Drain stage placed directly downstream of `buffer`. It pops words from the FIFO read port and presents them as an AXI4-Stream master, one packet of `pkt_len` beats per `start` command. A one-entry output register decouples `m_axis_tready` from the FIFO read path. It asserts `m_axis_tlast` on the final beat and pulses `done` once the packet is fully accepted.

## Interface
- `DWIDTH`, from `parameters.vh`: data width, shared with `buffer`.
- `LWIDTH`, 16: width of the packet-length field and the beat counters.
- `clk` input 1: the single clock; all logic is rising-edge.
- `xrst` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to send a packet; honoured only in S_IDLE.
- `pkt_len` input LWIDTH: beats in the packet; sampled when `start` is accepted.
- `busy` output 1: high in every state except S_IDLE.
- `done` output 1: one-cycle pulse after the last beat handshakes.
- `buf_isempty` input 1: from `buffer`.
- `buf_rdata` input DWIDTH: from `buffer`; head word, valid combinationally whenever not empty.
- `buf_re` output 1: to `buffer`; pops the head word at the next edge.
- `m_axis_tvalid` output 1: AXI4-Stream valid.
- `m_axis_tready` input 1: AXI4-Stream ready.
- `m_axis_tdata` output DWIDTH: AXI4-Stream data.
- `m_axis_tlast` output 1: AXI4-Stream last.
- `stall_cycles` output 32: backpressure counter (see Configuration).

## Operation
- FSM states:
  - **S_IDLE**: on `start` with `pkt_len` != 0, latch `pkt_len` into `r_len`, clear `r_popped` and `r_sent`, go to S_RUN. `start` with `pkt_len` == 0 is ignored.
  - **S_RUN**: pops and sends. When `r_sent` reaches `r_len`, go to S_DONE.
  - **S_DONE**: one cycle with `done` = 1, then S_IDLE.
- Pop condition: `buf_re = (state==S_RUN) && !buf_isempty && (r_popped != r_len) && (!r_valid || m_axis_tready)`.
- `buf_re` is combinational. It never asserts when the FIFO is empty and never pops beyond `r_len`.
- On a pop edge: `r_data <= buf_rdata`, `r_valid <= 1`, `r_popped++`, `r_last <= (r_popped == r_len-1)`.
- On a handshake (`m_axis_tvalid && m_axis_tready`) with no pop: `r_valid <= 0`.
- On a handshake, `r_sent++` in all cases.
- Handshake and pop in the same cycle: the register is reloaded, `r_valid` stays 1, and there is no bubble.
- `m_axis_tvalid = r_valid`, `m_axis_tdata = r_data`, `m_axis_tlast = r_valid && r_last`.
- AXI rule: once `m_axis_tvalid` is high, `tdata` and `tlast` hold until the handshake. `m_axis_tvalid` never depends on `m_axis_tready`.
- Counter arithmetic is unsigned LWIDTH. `pkt_len` = 2^LWIDTH-1 is the maximum packet.
- Reset values: state S_IDLE; `r_valid`, `r_last`, `done`, `busy`, `buf_re` = 0; `r_data` = 0; counters = 0; `stall_cycles` = 0.
- Reset asserted mid-packet aborts immediately. The output clears asynchronously and the partially sent packet is not resumed.

## Timing
- Word present at FIFO head in cycle N of S_RUN with the register free: `m_axis_tvalid` is high in cycle N+1.
- `start` in cycle N: first possible `buf_re` in cycle N+1.
- Sustained throughput: 1 beat/cycle while the FIFO is non-empty and `m_axis_tready` = 1.
- Last handshake in cycle M: `done` = 1 in cycle M+1 and `busy` = 0 in cycle M+2.
- `start` during `busy` is ignored and not queued.
- FIFO running empty mid-packet: `buf_re` stays 0, `tvalid` drops after the pending beat drains, and the block waits indefinitely.

## Configuration
- `STREAM_SENDER_STALL_CNT_EN` defined:
  - `stall_cycles` increments every cycle with `m_axis_tvalid && !m_axis_tready`.
  - It saturates at 2^32-1.
  - It clears on reset and on each accepted `start`.
- Undefined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- `parameters.vh` additionally holds `LWIDTH` and the state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
- One sub-module is natural: `axis_reg_slice`, the one-entry valid/data/last output register with the load/unload rules above.
- The FSM, counters and pop logic stay in `stream_sender`.

## Test plan
- Reset with FIFO preloaded with 4 words, then `start`, `pkt_len`=4, `m_axis_tready`=1:
  - 4 consecutive beats in order, `tlast` only on beat 4.
  - `done` 1 cycle later.
  - FIFO reads empty afterwards.
- `pkt_len`=3 with FIFO holding 5 words: exactly 3 `buf_re` pulses, 2 words remain, `tlast` on beat 3.
- Backpressure: `m_axis_tready` toggles 1,0,0,1,… over an 8-beat packet:
  - `tdata` and `tlast` stable while stalled.
  - No beat lost or duplicated.
  - `stall_cycles` equals the number of stalled cycles when the macro is defined, 0 otherwise.
- FIFO empties mid-packet after 2 of 6 words, then refills 10 cycles later:
  - `buf_re` never high while `buf_isempty`.
  - Packet completes with 6 beats.
- `start` with `pkt_len`=0, and `start` while `busy`: no state change, no `buf_re`, no `done`.
- `xrst` asserted asynchronously mid-packet with `tvalid`=1:
  - `tvalid`, `busy` and `buf_re` go to 0 immediately.
  - After release, a new `start` sends a clean packet.
